mdio_phy_responder: RTL and testbench
=====================================

Name: mdio_phy_responder

Overview:
- Clause-22 MDIO management responder for the PHY side of the serial link. It is the counterpart of the MDIO initiator that drives MDC and issues frames.
- Samples MDC and MDIO in the clk domain and decodes each 64-bit frame: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- For reads, drives read data back onto MDIO. For writes, issues write strobes.
- Register storage sits outside the block, behind a simple single-cycle register port.

Parameters:
- PREAMBLE_LEN, 32, consecutive 1s required before ST; 0 = preamble suppression (ST accepted directly from IDLE).
- SYNC_STAGES, 2, flops in the MDC/MDIO input synchronizers (min 2).
- BCAST_EN, 0, 1 = write frames to PHYAD 0 are also accepted; reads to PHYAD 0 are never driven.

Ports:
- clk  in  1  system clock; MDC period must be at least 8 clk periods.
- reset  in  1  synchronous, active-high.
- phy_addr  in  5  strapped PHY address, static during operation.
- mdc  in  1  management clock from initiator, asynchronous to clk.
- mdio_in  in  1  MDIO line as seen by the pad.
- mdio_out  out  1  value driven onto MDIO when mdio_oe=1.
- mdio_oe  out  1  output enable for the MDIO tristate.
- reg_addr  out  5  register address for the current access.
- reg_rd_en  out  1  one-clk read strobe.
- reg_rd_data  in  16  read data, valid 1 clk after reg_rd_en.
- reg_wr_en  out  1  one-clk write strobe.
- reg_wr_data  out  16  write data, valid while reg_wr_en=1.
- busy  out  1  high from ST accepted until frame end or abort.
- frame_err  out  1  one-clk pulse on an aborted frame.

Behaviour:
- Reset values: mdio_out=1, mdio_oe=0, reg_addr=0, reg_rd_en=0, reg_wr_en=0, reg_wr_data=0, busy=0, frame_err=0. Preamble counter=0, FSM=IDLE.
- Reset asserted mid-frame forces the same values on the next clk edge and releases MDIO immediately.
- Edge detection: mdc and mdio_in pass through SYNC_STAGES flops. An "MDC rise" is a 0->1 transition of the synchronized mdc; it lasts one clk. Every sampling and drive action below happens only in that clk cycle.
- Bit indices after preamble, k = 0..31:
  - ST = 0-1
  - OP = 2-3
  - PHYAD = 4-8
  - REGAD = 9-13
  - TA = 14-15
  - DATA = 16-31, MSB first.
- "Rise k" samples bit k.
- FSM states and transitions:
  - IDLE: counts consecutive sampled 1s, saturating at PREAMBLE_LEN. A sampled 0 with count >= PREAMBLE_LEN -> ST (bit 0 consumed, busy=1). A sampled 0 with fewer 1s resets the count.
  - ST: bit 1 must be 1, else abort.
  - OP: 10 = read, 01 = write; 00 or 11 -> abort.
  - PHYAD: shift in 5 bits. At rise 8, mismatch with phy_addr -> abort. Exception: BCAST_EN=1, write, PHYAD=0 is accepted.
  - REGAD: shift in 5 bits. At rise 13, reg_addr <= REGAD. For a read, reg_rd_en pulses in the same clk and reg_rd_data is captured into the shift register on the next clk.
  - TA_RD: rise 14 -> mdio_oe=1, mdio_out=0.
  - TA_WR: bit 14 must be 1 and bit 15 must be 0, else abort.
  - DATA_RD: rises 15..30 drive D15..D0. Rise 31 -> mdio_oe=0, mdio_out=1, busy=0, go to IDLE.
  - DATA_WR: shift in bits 16..31. At rise 31, reg_wr_data <= data and reg_wr_en pulses for 1 clk, busy=0, go to IDLE.
- Abort: frame_err pulses, busy=0, mdio_oe=0, return to IDLE with preamble count 0. A full preamble is required again, or none when PREAMBLE_LEN=0.
- After frame end, preamble count=0. Back-to-back frames need a new preamble unless PREAMBLE_LEN=0.
- mdio_oe never asserts for a write, for an address mismatch, or for a broadcast read.
- Strobes never fire for an aborted frame. reg_rd_en and reg_wr_en are mutually exclusive.
- MDC stopping mid-frame: state is held indefinitely; there is no timeout.

Decomposition:
- Package mdio_pkg holds:
  - OP_READ=2'b10, OP_WRITE=2'b01, ST_BITS=2'b01, TA_WR=2'b10.
  - Field widths: PHYAD_W=5, REGAD_W=5, DATA_W=16, FRAME_BITS=32.
  - FSM state enum.
  - Shared with the initiator and the bench.
- Sub-module mdio_edge_sync: SYNC_STAGES synchronizers for mdc and mdio_in. Outputs mdc_rise and mdio_s.

Test Plan:
- Write: phy_addr=5'h03. Send 32x1, 01, 01, 00011, 01010, 10, 16'hBEEF -> exactly one reg_wr_en pulse with reg_addr=5'h0A, reg_wr_data=16'hBEEF; mdio_oe never asserted; frame_err=0.
- Read: phy_addr=5'h03. Send 32x1, 01, 10, 00011, 00111, then release MDIO; reg_rd_data returns 16'h1234 -> reg_rd_en pulse with reg_addr=5'h07. Bench sampling on rises 15..30 reads 0 (TA) then 16'h1234. mdio_oe drops after rise 31.
- Address mismatch: same read with PHYAD=5'h04 -> frame_err pulse at rise 8; no strobes; mdio_oe stays 0. An immediately following valid frame without a new preamble is ignored.
- Short preamble / bad OP: 31x1 then a valid write -> no strobe. Full preamble with OP=11 -> frame_err; no strobe.
- Reset mid-read: assert reset at rise 20 -> next clk mdio_oe=0, busy=0. A following full write frame to REGAD 5'h01 with data 16'h0055 completes normally.
- Broadcast, BCAST_EN=1: write to PHYAD 0, REGAD 5'h00, data 16'h8000 -> reg_wr_en fires. Read to PHYAD 0 -> mdio_oe never asserted.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO definitions: frame field codes, field widths,
// responder FSM states and the PHY address acceptance rule.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_BITS  = 2'b01;
  localparam logic [1:0] TA_WR    = 2'b10;

  localparam int PHYAD_W    = 5;
  localparam int REGAD_W    = 5;
  localparam int DATA_W     = 16;
  localparam int FRAME_BITS = 32;

  // Bit index (after preamble) of the last bit of each field.
  localparam logic [4:0] K_ST_END    = 5'd1;
  localparam logic [4:0] K_OP_END    = 5'd3;
  localparam logic [4:0] K_PHYAD_END = 5'd8;
  localparam logic [4:0] K_REGAD_END = 5'd13;
  localparam logic [4:0] K_TA_END    = 5'd15;
  localparam logic [4:0] K_LAST      = 5'd31;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA_RD,
    S_TA_WR,
    S_DATA_RD,
    S_DATA_WR
  } mdio_state_e;

  // Address 0 is a broadcast alias for writes only when broadcast is
  // enabled; reads to address 0 are then never answered, so two PHYs
  // can never fight over the line.
  function automatic logic phyad_ok(input logic [PHYAD_W-1:0] rx_addr,
                                    input logic [PHYAD_W-1:0] strap_addr,
                                    input logic               is_wr,
                                    input logic               bcast_en);
    logic ok;
    ok = (rx_addr == strap_addr);
    if (bcast_en && (rx_addr == '0)) begin
      ok = is_wr;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Input synchronizers for MDC and MDIO, plus MDC rising-edge detection
// in the clk domain. Both lines see the same latency so MDIO is sampled
// coherently with the detected MDC rise.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdc_rise,
  output logic mdio_s
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] mdc_sync_q;
  logic [N-1:0] mdio_sync_q;
  logic         mdc_prev_q;

  // Synchronizer chains; reset to 1 so an MDC that is already high when
  // reset releases is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_sync_q  <= '1;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[N-2:0], mdc};
      mdio_sync_q <= {mdio_sync_q[N-2:0], mdio_in};
      mdc_prev_q  <= mdc_sync_q[N-1];
    end
  end

  assign mdc_rise = mdc_sync_q[N-1] & ~mdc_prev_q;
  assign mdio_s   = mdio_sync_q[N-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side). Decodes frames on MDC rises,
// drives read data back on MDIO and issues single-cycle register strobes.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_LEN = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int BCAST_EN     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHYAD_W-1:0] phy_addr,
  input  logic               mdc,
  input  logic               mdio_in,
  output logic               mdio_out,
  output logic               mdio_oe,
  output logic [REGAD_W-1:0] reg_addr,
  output logic               reg_rd_en,
  input  logic [DATA_W-1:0]  reg_rd_data,
  output logic               reg_wr_en,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic               busy,
  output logic               frame_err
);

  localparam int PCW = (PREAMBLE_LEN < 1) ? 1 : $clog2(PREAMBLE_LEN + 1);
  localparam logic [PCW-1:0] PRE_MAX = PCW'(PREAMBLE_LEN);

  logic mdc_rise;
  logic mdio_s;

  mdio_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .mdc     (mdc),
    .mdio_in (mdio_in),
    .mdc_rise(mdc_rise),
    .mdio_s  (mdio_s)
  );

  mdio_state_e         state_q;
  logic [PCW-1:0]      pre_cnt_q;
  logic [4:0]          bit_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                is_wr_q;
  logic                rd_cap_q;
  logic                mdio_out_q;
  logic                mdio_oe_q;
  logic [REGAD_W-1:0]  reg_addr_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                busy_q;
  logic                ferr_q;

  logic [DATA_W-1:0]   shift_d;
  logic [4:0]          k_d;
  logic                abort_d;

  // Next shift value, index of the bit being sampled and abort conditions.
  always_comb begin
    shift_d = {shift_q[DATA_W-2:0], mdio_s};
    k_d     = bit_cnt_q + 5'd1;
    abort_d = 1'b0;
    if (mdc_rise) begin
      case (state_q)
        S_ST:    abort_d = !mdio_s;
        S_OP:    abort_d = (k_d == K_OP_END) &&
                           (shift_d[1:0] != OP_READ) && (shift_d[1:0] != OP_WRITE);
        S_PHYAD: abort_d = (k_d == K_PHYAD_END) &&
                           !phyad_ok(shift_d[PHYAD_W-1:0], phy_addr, is_wr_q, BCAST_EN != 0);
        S_TA_WR: abort_d = (k_d == K_TA_END) && (shift_d[1:0] != TA_WR);
        default: abort_d = 1'b0;
      endcase
    end
  end

  // Frame FSM with registered outputs; all bus actions happen on MDC rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      is_wr_q    <= 1'b0;
      rd_cap_q   <= 1'b0;
      mdio_out_q <= 1'b1;
      mdio_oe_q  <= 1'b0;
      reg_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      ferr_q   <= 1'b0;
      rd_cap_q <= rd_en_q;
      // Read data arrives one clk after the strobe; long before rise 15.
      if (rd_cap_q) begin
        shift_q <= reg_rd_data;
      end

      if (abort_d) begin
        ferr_q     <= 1'b1;
        busy_q     <= 1'b0;
        mdio_oe_q  <= 1'b0;
        mdio_out_q <= 1'b1;
        pre_cnt_q  <= '0;
        state_q    <= S_IDLE;
      end else if (mdc_rise) begin
        if (state_q != S_IDLE) begin
          bit_cnt_q <= k_d;
        end
        case (state_q)
          S_IDLE: begin
            if (mdio_s) begin
              if (pre_cnt_q < PRE_MAX) begin
                pre_cnt_q <= pre_cnt_q + 1'b1;
              end
            end else if (pre_cnt_q >= PRE_MAX) begin
              // This 0 is ST bit 0.
              state_q   <= S_ST;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
              pre_cnt_q <= '0;
            end else begin
              pre_cnt_q <= '0;
            end
          end

          S_ST: begin
            shift_q <= shift_d;
            state_q <= S_OP;
          end

          S_OP: begin
            shift_q <= shift_d;
            if (k_d == K_OP_END) begin
              is_wr_q <= (shift_d[1:0] == OP_WRITE);
              state_q <= S_PHYAD;
            end
          end

          S_PHYAD: begin
            shift_q <= shift_d;
            if (k_d == K_PHYAD_END) begin
              state_q <= S_REGAD;
            end
          end

          S_REGAD: begin
            shift_q <= shift_d;
            if (k_d == K_REGAD_END) begin
              reg_addr_q <= shift_d[REGAD_W-1:0];
              if (is_wr_q) begin
                state_q <= S_TA_WR;
              end else begin
                rd_en_q <= 1'b1;
                state_q <= S_TA_RD;
              end
            end
          end

          S_TA_RD: begin
            mdio_oe_q  <= 1'b1;
            mdio_out_q <= 1'b0;
            state_q    <= S_DATA_RD;
          end

          S_TA_WR: begin
            shift_q <= shift_d;
            if (k_d == K_TA_END) begin
              state_q <= S_DATA_WR;
            end
          end

          S_DATA_RD: begin
            if (k_d == K_LAST) begin
              mdio_oe_q  <= 1'b0;
              mdio_out_q <= 1'b1;
              busy_q     <= 1'b0;
              pre_cnt_q  <= '0;
              state_q    <= S_IDLE;
            end else begin
              mdio_out_q <= shift_q[DATA_W-1];
              shift_q    <= {shift_q[DATA_W-2:0], 1'b0};
            end
          end

          S_DATA_WR: begin
            shift_q <= shift_d;
            if (k_d == K_LAST) begin
              wr_data_q <= shift_d;
              wr_en_q   <= 1'b1;
              busy_q    <= 1'b0;
              pre_cnt_q <= '0;
              state_q   <= S_IDLE;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Reset releases the line combinationally, ahead of the registered clear.
  assign mdio_oe     = mdio_oe_q & ~reset;
  assign mdio_out    = mdio_out_q;
  assign reg_addr    = reg_addr_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: one unit at the default
// parameters and one with broadcast enabled, both strapped to 5'h03.
module tb_mdio_phy_responder;
  import mdio_pkg::*;

  localparam logic [4:0] PHY = 5'h03;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic mdc;
  logic tb_drv;
  logic tb_drv_en;

  logic        mdio_out_a, mdio_oe_a, rd_en_a, wr_en_a, busy_a, ferr_a, line_a;
  logic [4:0]  reg_addr_a;
  logic [15:0] rd_data_a, wr_data_a;
  logic        mdio_out_b, mdio_oe_b, rd_en_b, wr_en_b, busy_b, ferr_b, line_b;
  logic [4:0]  reg_addr_b;
  logic [15:0] rd_data_b, wr_data_b;

  // Open-drain style bus with pull-up when nobody drives.
  assign line_a    = mdio_oe_a ? mdio_out_a : (tb_drv_en ? tb_drv : 1'b1);
  assign line_b    = mdio_oe_b ? mdio_out_b : (tb_drv_en ? tb_drv : 1'b1);
  assign rd_data_b = 16'hFFFF;

  mdio_phy_responder dut (
    .clk(clk), .reset(reset), .phy_addr(PHY), .mdc(mdc), .mdio_in(line_a),
    .mdio_out(mdio_out_a), .mdio_oe(mdio_oe_a), .reg_addr(reg_addr_a),
    .reg_rd_en(rd_en_a), .reg_rd_data(rd_data_a), .reg_wr_en(wr_en_a),
    .reg_wr_data(wr_data_a), .busy(busy_a), .frame_err(ferr_a)
  );

  mdio_phy_responder #(.BCAST_EN(1)) dut_bc (
    .clk(clk), .reset(reset), .phy_addr(PHY), .mdc(mdc), .mdio_in(line_b),
    .mdio_out(mdio_out_b), .mdio_oe(mdio_oe_b), .reg_addr(reg_addr_b),
    .reg_rd_en(rd_en_b), .reg_rd_data(rd_data_b), .reg_wr_en(wr_en_b),
    .reg_wr_data(wr_data_b), .busy(busy_b), .frame_err(ferr_b)
  );

  // Register port model: data one clk after the read strobe.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= (reg_addr_a == 5'h07) ? 16'h1234 : {11'h0, reg_addr_a};
  end

  int wr_cnt_a = 0, rd_cnt_a = 0, oe_cnt_a = 0, ferr_cnt_a = 0, excl_cnt = 0;
  int wr_cnt_b = 0, rd_cnt_b = 0, oe_cnt_b = 0, ferr_cnt_b = 0;
  logic [4:0]  last_wa_a = '0, last_wa_b = '0;
  logic [15:0] last_wd_a = '0, last_wd_b = '0;

  always @(negedge clk) begin
    if (wr_en_a) begin
      wr_cnt_a  <= wr_cnt_a + 1;
      last_wa_a <= reg_addr_a;
      last_wd_a <= wr_data_a;
    end
    if (rd_en_a)   rd_cnt_a   <= rd_cnt_a + 1;
    if (mdio_oe_a) oe_cnt_a   <= oe_cnt_a + 1;
    if (ferr_a)    ferr_cnt_a <= ferr_cnt_a + 1;
    if ((rd_en_a && wr_en_a) || (rd_en_b && wr_en_b)) excl_cnt <= excl_cnt + 1;
    if (wr_en_b) begin
      wr_cnt_b  <= wr_cnt_b + 1;
      last_wa_b <= reg_addr_b;
      last_wd_b <= wr_data_b;
    end
    if (rd_en_b)   rd_cnt_b   <= rd_cnt_b + 1;
    if (mdio_oe_b) oe_cnt_b   <= oe_cnt_b + 1;
    if (ferr_b)    ferr_cnt_b <= ferr_cnt_b + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic s_out, s_oe, s_busy;
  logic ta_out, ta_oe, oe_end, busy_mid;
  logic [15:0] rd_word;
  int ferr_at8;
  int w0, r0, o0, f0, wb0, rb0, ob0, fb0;

  // One MDC period: data set while MDC low, sampled at the end of the high half.
  task automatic mdc_bit(input logic b);
    tb_drv = b;
    repeat (5) @(posedge clk);
    mdc = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_out  = mdio_out_a;
    s_oe   = mdio_oe_a;
    s_busy = busy_a;
    mdc    = 1'b0;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] data, input int rst_at);
    logic [31:0] bits;
    logic rd;
    rd   = (op == OP_READ);
    bits = {ST_BITS, op, pa, ra, TA_WR, data};
    tb_drv_en = 1'b1;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1);
    for (int k = 0; k < 32; k++) begin
      if (rd && k >= 14) tb_drv_en = 1'b0;
      mdc_bit(bits[31-k]);
      if (k == 5)  busy_mid = s_busy;
      if (k == 8)  ferr_at8 = ferr_cnt_a;
      if (k == 14) begin ta_out = s_out; ta_oe = s_oe; end
      if (k >= 15 && k <= 30) rd_word = {rd_word[14:0], s_out};
      if (k == 31) oe_end = s_oe;
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_oe_now", {31'b0, mdio_oe_a}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_oe_next", {31'b0, mdio_oe_a}, 32'd0);
        check("rst_busy_next", {31'b0, busy_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        break;
      end
    end
    tb_drv_en = 1'b1;
    tb_drv    = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    w0 = wr_cnt_a; r0 = rd_cnt_a; o0 = oe_cnt_a; f0 = ferr_cnt_a;
    wb0 = wr_cnt_b; rb0 = rd_cnt_b; ob0 = oe_cnt_b; fb0 = ferr_cnt_b;
  endtask

  initial begin
    reset = 1'b1; mdc = 1'b0; tb_drv = 1'b1; tb_drv_en = 1'b1;
    rd_word = '0; ferr_at8 = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_oe",      {31'b0, mdio_oe_a},  32'd0);
    check("rst_out",     {31'b0, mdio_out_a}, 32'd1);
    check("rst_busy",    {31'b0, busy_a},     32'd0);
    check("rst_addr",    {27'b0, reg_addr_a}, 32'd0);
    check("rst_wdata",   {16'b0, wr_data_a},  32'd0);
    check("rst_strobes", {29'b0, rd_en_a, wr_en_a, ferr_a}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write 16'hBEEF to register 5'h0A
    snap();
    send_frame(32, OP_WRITE, PHY, 5'h0A, 16'hBEEF, -1);
    check("wr_count",  wr_cnt_a - w0,   1);
    check("wr_addr",   {27'b0, last_wa_a}, 32'h0A);
    check("wr_data",   {16'b0, last_wd_a}, 32'hBEEF);
    check("wr_no_oe",  oe_cnt_a - o0,   0);
    check("wr_no_err", ferr_cnt_a - f0, 0);
    check("wr_no_rd",  rd_cnt_a - r0,   0);
    check("wr_busy_mid", {31'b0, busy_mid}, 32'd1);
    check("wr_busy_end", {31'b0, busy_a},   32'd0);

    // Read register 5'h07 (returns 16'h1234)
    do_reset();
    snap();
    send_frame(32, OP_READ, PHY, 5'h07, 16'h0000, -1);
    check("rd_count",  rd_cnt_a - r0, 1);
    check("rd_addr",   {27'b0, reg_addr_a}, 32'h07);
    check("rd_ta_oe",  {31'b0, ta_oe},  32'd1);
    check("rd_ta_out", {31'b0, ta_out}, 32'd0);
    check("rd_data",   {16'b0, rd_word}, 32'h1234);
    check("rd_oe_end", {31'b0, oe_end}, 32'd0);
    check("rd_no_wr",  wr_cnt_a - w0, 0);
    check("rd_no_err", ferr_cnt_a - f0, 0);

    // Address mismatch, then a frame with no preamble
    do_reset();
    snap();
    send_frame(32, OP_READ, 5'h04, 5'h07, 16'h0000, -1);
    check("mis_err_at8", ferr_at8 - f0,  1);
    check("mis_err",     ferr_cnt_a - f0, 1);
    check("mis_no_rd",   rd_cnt_a - r0,  0);
    check("mis_no_oe",   oe_cnt_a - o0,  0);
    snap();
    send_frame(0, OP_WRITE, PHY, 5'h0A, 16'hBEEF, -1);
    check("nopre_no_wr",  wr_cnt_a - w0,   0);
    check("nopre_no_err", ferr_cnt_a - f0, 0);

    // 31-bit preamble is too short
    do_reset();
    snap();
    send_frame(31, OP_WRITE, PHY, 5'h0A, 16'h1111, -1);
    check("short_no_wr",  wr_cnt_a - w0,   0);
    check("short_no_err", ferr_cnt_a - f0, 0);

    // OP = 11 aborts
    do_reset();
    snap();
    send_frame(32, 2'b11, PHY, 5'h0A, 16'h1111, -1);
    check("op11_err",   ferr_cnt_a - f0, 1);
    check("op11_no_wr", wr_cnt_a - w0,   0);
    check("op11_no_rd", rd_cnt_a - r0,   0);

    // Reset during a read, then a normal write
    do_reset();
    send_frame(32, OP_READ, PHY, 5'h07, 16'h0000, 20);
    snap();
    send_frame(32, OP_WRITE, PHY, 5'h01, 16'h0055, -1);
    check("post_rst_wr_count", wr_cnt_a - w0, 1);
    check("post_rst_wr_addr",  {27'b0, last_wa_a}, 32'h01);
    check("post_rst_wr_data",  {16'b0, last_wd_a}, 32'h0055);
    check("post_rst_no_err",   ferr_cnt_a - f0, 0);

    // Broadcast write and read to PHYAD 0
    do_reset();
    snap();
    send_frame(32, OP_WRITE, 5'h00, 5'h00, 16'h8000, -1);
    check("bc_wr_count", wr_cnt_b - wb0, 1);
    check("bc_wr_addr",  {27'b0, last_wa_b}, 32'h00);
    check("bc_wr_data",  {16'b0, last_wd_b}, 32'h8000);
    check("nobc_no_wr",  wr_cnt_a - w0,   0);
    check("nobc_err",    ferr_cnt_a - f0, 1);
    do_reset();
    snap();
    send_frame(32, OP_READ, 5'h00, 5'h07, 16'h0000, -1);
    check("bc_rd_no_oe", oe_cnt_b - ob0, 0);
    check("bc_rd_no_rd", rd_cnt_b - rb0, 0);
    check("bc_rd_err",   ferr_cnt_b - fb0, 1);
    check("bc_rd_busy",  {31'b0, busy_b}, 32'd0);

    check("strobe_excl", excl_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
